// File: rtl/cpu_sram_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// cpu_sram_arbiter_pkg
//   Shared types for the two-master sram-like bus arbiter: FSM state codes,
//   owner codes and the bundled memory command.
// ---------------------------------------------------------------------------
package cpu_sram_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SIZE_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

  // Request fields travelling together from a master to the memory port.
  typedef struct packed {
    logic              wr;
    logic [SIZE_W-1:0] size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/cpu_sram_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
//   Combinational two-way grant between the instruction and data masters.
//   Ports:
//     inst_req_i, data_req_i : live requests
//     last_grant_i           : owner of the most recently accepted address
//     grant_o                : master to own the next transaction
//   RR_EN = 1 alternates on ties; RR_EN = 0 gives data fixed priority.
// ---------------------------------------------------------------------------
module rr_arb2
  import cpu_sram_arbiter_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic   inst_req_i,
  input  logic   data_req_i,
  input  owner_e last_grant_i,
  output owner_e grant_o
);

  always_comb begin
    // NOTE: default first so every path assigns grant_o and no latch is inferred.
    grant_o = OWN_INST;
    if (data_req_i && !inst_req_i) begin
      grant_o = OWN_DATA;
    end else if (data_req_i && inst_req_i) begin
      if (RR_EN) begin
        grant_o = (last_grant_i == OWN_DATA) ? OWN_INST : OWN_DATA;
      end else begin
        grant_o = OWN_DATA;
      end
    end
  end

endmodule

// File: rtl/cpu_sram_arbiter.sv
// ---------------------------------------------------------------------------
// cpu_sram_arbiter
//   Shares one sram-like memory port between the instruction-fetch master
//   and the data master, one outstanding transaction at a time.
//   Ports:
//     clk, reset                 : clock, synchronous active-high reset
//     inst_* / data_* (in)       : master requests and fields, held until addr_ok
//     inst_* / data_* (out)      : addr_ok / data_ok / rdata back to each master
//     mem_* (out)                : request forwarded from the current owner
//     mem_addr_ok/data_ok/rdata  : memory responses
//   Flow: IDLE picks an owner, ADDR presents the request until mem_addr_ok,
//   DATA waits for mem_data_ok. One bubble cycle separates transactions.
// ---------------------------------------------------------------------------
module cpu_sram_arbiter
  import cpu_sram_arbiter_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  state_e   state_q;
  owner_e   owner_q;
  owner_e   last_grant_q;
  owner_e   grant;
  logic     mem_req_q;
  logic     addr_hit;
  logic     data_hit;
  mem_cmd_t inst_cmd;
  mem_cmd_t data_cmd;
  mem_cmd_t sel_cmd;

  rr_arb2 #(
    .RR_EN(RR_EN)
  ) u_rr_arb2 (
    .inst_req_i  (inst_req),
    .data_req_i  (data_req),
    .last_grant_i(last_grant_q),
    .grant_o     (grant)
  );

  // mem_req_q is high exactly while in ADDR; keeping it as its own register
  // gives a glitch-free request line.
  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge, and all state uses non-blocking
    // assignments so every register sees pre-edge values.
    if (reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_INST;
      last_grant_q <= OWN_INST;
      mem_req_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (inst_req || data_req) begin
            owner_q   <= grant;
            mem_req_q <= 1'b1;
            state_q   <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (mem_addr_ok) begin
            last_grant_q <= owner_q;
            mem_req_q    <= 1'b0;
            state_q      <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (mem_data_ok) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          mem_req_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  assign inst_cmd = {inst_wr, inst_size, inst_addr, inst_wdata};
  assign data_cmd = {data_wr, data_size, data_addr, data_wdata};
  assign sel_cmd  = (owner_q == OWN_DATA) ? data_cmd : inst_cmd;

  assign mem_req   = mem_req_q;
  assign mem_wr    = sel_cmd.wr;
  assign mem_size  = sel_cmd.size;
  assign mem_addr  = sel_cmd.addr;
  assign mem_wdata = sel_cmd.wdata;

  // NOTE: handshakes pass straight through in the same cycle; responses that
  // arrive outside the matching state are dropped here.
  assign addr_hit = mem_req_q && mem_addr_ok;
  assign data_hit = (state_q == ST_DATA) && mem_data_ok;

  assign inst_addr_ok = addr_hit && (owner_q == OWN_INST);
  assign data_addr_ok = addr_hit && (owner_q == OWN_DATA);
  assign inst_data_ok = data_hit && (owner_q == OWN_INST);
  assign data_data_ok = data_hit && (owner_q == OWN_DATA);

  // Read data is broadcast; only *_data_ok qualifies it.
  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;

endmodule

// File: tb/tb_cpu_sram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cpu_sram_arbiter
//   Instance 0 uses round-robin tie-break, instance 1 fixed data priority.
//   Each test drives only one instance; the other sits idle.
// ---------------------------------------------------------------------------
module tb_cpu_sram_arbiter;

  logic clk = 1'b0;
  logic reset;

  logic        ireq [2], iwr [2], dreq [2], dwr [2], mao [2], mdo [2];
  logic [1:0]  isize [2], dsize [2];
  logic [31:0] iaddr [2], iwdata [2], daddr [2], dwdata [2], mrdata [2];

  logic        iao [2], ido [2], dao [2], ddo [2], mreq [2], mwr [2];
  logic [1:0]  msize [2];
  logic [31:0] irdata [2], drdata [2], maddr [2], mwdata [2];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    cpu_sram_arbiter #(
      .RR_EN(g == 0)
    ) u_dut (
      .clk         (clk),
      .reset       (reset),
      .inst_req    (ireq[g]),
      .inst_wr     (iwr[g]),
      .inst_size   (isize[g]),
      .inst_addr   (iaddr[g]),
      .inst_wdata  (iwdata[g]),
      .inst_addr_ok(iao[g]),
      .inst_data_ok(ido[g]),
      .inst_rdata  (irdata[g]),
      .data_req    (dreq[g]),
      .data_wr     (dwr[g]),
      .data_size   (dsize[g]),
      .data_addr   (daddr[g]),
      .data_wdata  (dwdata[g]),
      .data_addr_ok(dao[g]),
      .data_data_ok(ddo[g]),
      .data_rdata  (drdata[g]),
      .mem_req     (mreq[g]),
      .mem_wr      (mwr[g]),
      .mem_size    (msize[g]),
      .mem_addr    (maddr[g]),
      .mem_wdata   (mwdata[g]),
      .mem_addr_ok (mao[g]),
      .mem_data_ok (mdo[g]),
      .mem_rdata   (mrdata[g])
    );
  end

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Fields the given master is presenting (0 = inst, 1 = data).
  function automatic logic [66:0] fields_of(int k, bit own);
    return own ? {dwr[k], dsize[k], daddr[k], dwdata[k]}
               : {iwr[k], isize[k], iaddr[k], iwdata[k]};
  endfunction

  function automatic logic [66:0] mem_fields(int k);
    return {mwr[k], msize[k], maddr[k], mwdata[k]};
  endfunction

  // {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}
  function automatic logic [3:0] acks(int k);
    return {iao[k], dao[k], ido[k], ddo[k]};
  endfunction

  function automatic logic [3:0] ack_vec(bit own, bit ahit, bit dhit);
    return {ahit && !own, ahit && own, dhit && !own, dhit && own};
  endfunction

  // Tie-break rule: a lone requester wins; on a tie data wins unless
  // round-robin says it was served last.
  function automatic bit pick(bit ir, bit dr, bit rr, bit last);
    if (ir && dr) return rr ? !last : 1'b1;
    return dr;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      ireq[k] = 1'b0; iwr[k] = 1'b0; isize[k] = 2'd2; iaddr[k] = '0; iwdata[k] = '0;
      dreq[k] = 1'b0; dwr[k] = 1'b0; dsize[k] = 2'd2; daddr[k] = '0; dwdata[k] = '0;
      mao[k] = 1'b0; mdo[k] = 1'b0; mrdata[k] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      mao[k] = 1'b1;
      mdo[k] = 1'b1;
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("reset%0d_state", k), 96'({mreq[k], acks(k)}), 96'(0));
      mao[k] = 1'b0;
      mdo[k] = 1'b0;
    end
  endtask

  // Serves one transaction on instance k from an IDLE cycle: expects mem_req
  // after exactly one idle cycle, owner 'own', addr_ok after a_lat wait
  // cycles and data_ok after d_lat wait cycles.
  task automatic serve(input int k, input bit own, input int a_lat, input int d_lat,
                       input bit drop, input string tag);
    int gap;
    gap    = 0;
    mao[k] = (a_lat == 0);
    forever begin
      @(negedge clk);
      if (mreq[k]) break;
      gap++;
      if (gap > 8) begin
        checks++;
        failures++;
        $display("FAIL %s_timeout: mem_req never rose, required within 8 cycles", tag);
        mao[k] = 1'b0;
        return;
      end
      @(posedge clk);
    end
    check({tag, "_gap"}, 96'(gap), 96'(1));
    for (int i = 0; i <= a_lat; i++) begin
      check({tag, "_a_req"}, 96'(mreq[k]), 96'(1));
      check({tag, "_a_fields"}, 96'(mem_fields(k)), 96'(fields_of(k, own)));
      check({tag, "_a_ack"}, 96'(acks(k)), 96'(ack_vec(own, i == a_lat, 1'b0)));
      if (i < a_lat) begin
        @(posedge clk); #1;
        mao[k] = (i + 1 == a_lat);
        @(negedge clk);
      end
    end
    @(posedge clk); #1;
    mao[k] = 1'b0;
    if (drop) begin
      if (own) dreq[k] = 1'b0;
      else     ireq[k] = 1'b0;
    end
    mrdata[k] = $urandom;
    mdo[k]    = (d_lat == 0);
    for (int i = 0; i <= d_lat; i++) begin
      @(negedge clk);
      check({tag, "_d_req"}, 96'(mreq[k]), 96'(0));
      check({tag, "_d_ack"}, 96'(acks(k)), 96'(ack_vec(own, 1'b0, i == d_lat)));
      if (i == d_lat)
        check({tag, "_rdata"}, 96'({irdata[k], drdata[k]}), 96'({mrdata[k], mrdata[k]}));
      if (i < d_lat) begin
        @(posedge clk); #1;
        mdo[k] = (i + 1 == d_lat);
      end
    end
    @(posedge clk); #1;
    mdo[k] = 1'b0;
  endtask

  typedef struct {
    bit       ir, dr, mao, mdo;
    bit       req;
    bit [3:0] ack;  // {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}
    bit       own;
  } vec_t;

  vec_t tbl [20];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Cycle-by-cycle vectors on the round-robin instance, starting in IDLE
    // straight after reset. Inst 0xBFC00000, data 0x80001004.
    tbl[0]  = '{1, 0, 0, 1, 0, 4'b0000, 0};  // inst req, spurious data_ok in IDLE
    tbl[1]  = '{1, 0, 1, 1, 1, 4'b1000, 0};  // ADDR: addr_ok passes, data_ok ignored
    tbl[2]  = '{0, 0, 0, 0, 0, 4'b0000, 0};  // DATA wait
    tbl[3]  = '{0, 0, 0, 1, 0, 4'b0010, 0};  // inst data_ok
    tbl[4]  = '{1, 1, 0, 0, 0, 4'b0000, 0};  // tie, last = inst
    tbl[5]  = '{1, 1, 0, 1, 1, 4'b0000, 1};  // data owns, spurious data_ok in ADDR
    tbl[6]  = '{1, 1, 1, 0, 1, 4'b0100, 1};
    tbl[7]  = '{1, 1, 1, 1, 0, 4'b0001, 0};  // spurious addr_ok in DATA
    tbl[8]  = '{1, 1, 0, 0, 0, 4'b0000, 0};  // bubble, last = data
    tbl[9]  = '{1, 1, 1, 0, 1, 4'b1000, 0};
    tbl[10] = '{0, 1, 0, 1, 0, 4'b0010, 0};
    tbl[11] = '{1, 1, 0, 0, 0, 4'b0000, 0};  // bubble, last = inst
    tbl[12] = '{1, 1, 1, 0, 1, 4'b0100, 1};
    tbl[13] = '{1, 0, 0, 1, 0, 4'b0001, 0};
    tbl[14] = '{1, 0, 0, 0, 0, 4'b0000, 0};  // lone inst request
    tbl[15] = '{1, 0, 1, 0, 1, 4'b1000, 0};
    tbl[16] = '{0, 0, 0, 0, 0, 4'b0000, 0};
    tbl[17] = '{0, 0, 0, 1, 0, 4'b0010, 0};
    tbl[18] = '{0, 0, 1, 1, 0, 4'b0000, 0};  // spurious both in IDLE
    tbl[19] = '{0, 0, 0, 0, 0, 4'b0000, 0};

    do_reset();
    iaddr[0]  = 32'hBFC00000;
    daddr[0]  = 32'h80001004;
    dwdata[0] = 32'h11111111;
    mrdata[0] = 32'h3C1D0000;
    for (int r = 0; r < 20; r++) begin
      ireq[0] = tbl[r].ir;
      dreq[0] = tbl[r].dr;
      mao[0]  = tbl[r].mao;
      mdo[0]  = tbl[r].mdo;
      #1;
      check($sformatf("vec%0d_req", r), 96'(mreq[0]), 96'(tbl[r].req));
      check($sformatf("vec%0d_ack", r), 96'(acks(0)), 96'(tbl[r].ack));
      check($sformatf("vec%0d_rdata", r), 96'({irdata[0], drdata[0]}),
            96'({32'h3C1D0000, 32'h3C1D0000}));
      if (tbl[r].req)
        check($sformatf("vec%0d_fields", r), 96'(mem_fields(0)), 96'(fields_of(0, tbl[r].own)));
      @(posedge clk); #1;
    end

    // Round-robin alternation with both masters held.
    do_reset();
    ireq[0] = 1'b1; iaddr[0] = 32'hBFC00010;
    dreq[0] = 1'b1; daddr[0] = 32'h80002000;
    serve(0, 1'b1, 0, 0, 1'b0, "rr_d0");
    serve(0, 1'b0, 1, 0, 1'b0, "rr_i0");
    serve(0, 1'b1, 0, 2, 1'b0, "rr_d1");
    serve(0, 1'b0, 0, 1, 1'b1, "rr_i1");

    // Fixed data priority: inst waits until data_req drops.
    do_reset();
    ireq[1] = 1'b1; iaddr[1] = 32'hBFC00000;
    dreq[1] = 1'b1; daddr[1] = 32'h80001004;
    serve(1, 1'b1, 0, 0, 1'b0, "fp_d0");
    serve(1, 1'b1, 1, 1, 1'b0, "fp_d1");
    serve(1, 1'b1, 0, 2, 1'b1, "fp_d2");
    serve(1, 1'b0, 0, 0, 1'b1, "fp_i");

    // Data write with addr_ok delayed by 4 cycles.
    do_reset();
    dreq[0] = 1'b1; dwr[0] = 1'b1; dsize[0] = 2'd2;
    daddr[0] = 32'h80001004; dwdata[0] = 32'hDEADBEEF;
    serve(0, 1'b1, 4, 1, 1'b1, "wr");

    // Reset while data owns the DATA phase: the next tie must go to data.
    do_reset();
    dreq[0] = 1'b1; daddr[0] = 32'h80003000;
    iaddr[0] = 32'hBFC00020;
    mao[0] = 1'b1;
    @(posedge clk); #2;
    check("rst_addr", 96'({mreq[0], dao[0]}), 96'(2'b11));
    @(posedge clk); #1;
    dreq[0] = 1'b0; mao[0] = 1'b0; reset = 1'b1;
    #1;
    check("rst_in_data", 96'({mreq[0], acks(0)}), 96'(0));
    @(posedge clk); #1;
    reset = 1'b0; ireq[0] = 1'b1; dreq[0] = 1'b1; mdo[0] = 1'b1;
    #1;
    check("rst_idle", 96'({mreq[0], acks(0)}), 96'(0));
    serve(0, 1'b1, 0, 0, 1'b1, "rst_tie");

    // Randomised traffic against a transaction-level reference model.
    for (int k = 0; k < 2; k++) begin
      bit       busy, acc, mst, last, got_i, got_d, e_req;
      logic [3:0] e_ack;
      do_reset();
      busy = 0; acc = 0; mst = 0; last = 0; got_i = 0; got_d = 0;
      for (int c = 0; c < 400; c++) begin
        // Masters hold their request until the model says it was accepted.
        if (!ireq[k] || got_i) begin
          ireq[k] = ($urandom_range(2) == 0);
          iwr[k] = 1'($urandom); isize[k] = 2'($urandom);
          iaddr[k] = $urandom; iwdata[k] = $urandom;
        end
        if (!dreq[k] || got_d) begin
          dreq[k] = ($urandom_range(2) == 0);
          dwr[k] = 1'($urandom); dsize[k] = 2'($urandom);
          daddr[k] = $urandom; dwdata[k] = $urandom;
        end
        mao[k]    = ($urandom_range(2) == 0);
        mdo[k]    = ($urandom_range(2) == 0);
        mrdata[k] = $urandom;
        #1;
        e_req = busy && !acc;
        e_ack = ack_vec(mst, e_req && mao[k], busy && acc && mdo[k]);
        check($sformatf("rnd%0d_c%0d_req", k, c), 96'(mreq[k]), 96'(e_req));
        check($sformatf("rnd%0d_c%0d_ack", k, c), 96'(acks(k)), 96'(e_ack));
        check($sformatf("rnd%0d_c%0d_rdata", k, c), 96'({irdata[k], drdata[k]}),
              96'({mrdata[k], mrdata[k]}));
        if (e_req)
          check($sformatf("rnd%0d_c%0d_fields", k, c), 96'(mem_fields(k)), 96'(fields_of(k, mst)));
        got_i = e_req && mao[k] && !mst;
        got_d = e_req && mao[k] && mst;
        if (!busy) begin
          if (ireq[k] || dreq[k]) begin
            busy = 1'b1;
            acc  = 1'b0;
            mst  = pick(ireq[k], dreq[k], k == 0, last);
          end
        end else if (!acc) begin
          if (mao[k]) begin
            acc  = 1'b1;
            last = mst;
          end
        end else if (mdo[k]) begin
          busy = 1'b0;
        end
        @(posedge clk); #1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
